// File: rtl/radix2_div_unit.sv
// Radix-2 restoring divider for the RV32 M-extension (div/divu/rem/remu).
// One quotient bit per cycle; divide-by-zero and signed overflow optionally resolve in one cycle.
module radix2_div_unit #(
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        div_enable,
  input  logic [2:0]  funct3,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] f,
  output logic        div_resp
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        rem_sel_q, rem_sel_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic        div0_q, div0_d;
  logic        ovf_q, ovf_d;
  logic [31:0] dvd_q, dvd_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] f_q, f_d;

  function automatic logic [31:0] apply_sign(input logic [31:0] v, input logic neg);
    return neg ? (32'd0 - v) : v;
  endfunction

  logic        is_signed, a_neg, b_neg, acc_div0, acc_ovf;
  logic [31:0] a_mag, b_mag, fast_res;

  always_comb begin
    is_signed = ~funct3[0];
    a_neg     = is_signed & a[31];
    b_neg     = is_signed & b[31];
    a_mag     = apply_sign(a, a_neg);
    b_mag     = apply_sign(b, b_neg);
    acc_div0  = (b == 32'd0);
    acc_ovf   = is_signed && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    if (funct3[1]) fast_res = acc_div0 ? a : 32'd0;
    else           fast_res = acc_div0 ? 32'hFFFF_FFFF : 32'h8000_0000;
  end

  // The 33-bit partial remainder only exists as the shifted trial value; the
  // kept remainder is always below the divisor and fits in 32 bits.
  logic [32:0] shifted, diff;
  logic        fits;
  logic [31:0] rem_step, quo_step, quo_fix, rem_fix, calc_res;

  always_comb begin
    shifted  = {rem_q, dvd_q[31]};
    diff     = shifted - {1'b0, dvs_q};
    fits     = ~diff[32];
    rem_step = fits ? diff[31:0] : shifted[31:0];
    quo_step = {dvd_q[30:0], fits};
    if (div0_q)     quo_fix = 32'hFFFF_FFFF;
    else if (ovf_q) quo_fix = 32'h8000_0000;
    else            quo_fix = apply_sign(quo_step, neg_quo_q);
    rem_fix  = ovf_q ? 32'd0 : apply_sign(rem_step, neg_rem_q);
    calc_res = rem_sel_q ? rem_fix : quo_fix;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_sel_d = rem_sel_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    ovf_d     = ovf_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    f_d       = f_q;
    unique case (state_q)
      IDLE: begin
        if (div_enable && funct3[2]) begin
          rem_sel_d = funct3[1];
          neg_quo_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          div0_d    = acc_div0;
          ovf_d     = acc_ovf;
          dvd_d     = a_mag;
          dvs_d     = b_mag;
          rem_d     = 32'd0;
          cnt_d     = 5'd0;
          if (EARLY_OUT && (acc_div0 || acc_ovf)) begin
            state_d = DONE;
            f_d     = fast_res;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (!div_enable) begin
          state_d = IDLE;
          cnt_d   = 5'd0;
        end else begin
          dvd_d = quo_step;
          rem_d = rem_step;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d = DONE;
            f_d     = calc_res;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      rem_sel_q <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      ovf_q     <= 1'b0;
      dvd_q     <= 32'd0;
      dvs_q     <= 32'd0;
      rem_q     <= 32'd0;
      f_q       <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_sel_q <= rem_sel_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      ovf_q     <= ovf_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      f_q       <= f_d;
    end
  end

  assign f        = f_q;
  assign div_resp = (state_q == DONE);

endmodule

// File: tb/tb_radix2_div_unit.sv
// Directed bench for radix2_div_unit: one unit with the fast path, one without.
module tb_radix2_div_unit;

  logic        clk, rst, en1, en0;
  logic [2:0]  fn;
  logic [31:0] a, b, f1, f0;
  logic        resp1, resp0;
  int          checks, errors;
  logic [31:0] exp_f1;

  radix2_div_unit #(.EARLY_OUT(1'b1)) dut1 (
    .clk(clk), .rst(rst), .div_enable(en1), .funct3(fn), .a(a), .b(b), .f(f1), .div_resp(resp1)
  );
  radix2_div_unit #(.EARLY_OUT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .div_enable(en0), .funct3(fn), .a(a), .b(b), .f(f0), .div_resp(resp0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  // Starts at posedge+1 with the unit idle; returns at posedge+1 with the unit idle again.
  task automatic run_op(input bit slow, input logic [2:0] fn_i, input logic [31:0] a_i,
                        input logic [31:0] b_i, output int lat, output logic [31:0] res,
                        output logic after);
    fn = fn_i; a = a_i; b = b_i;
    if (slow) en0 = 1'b1; else en1 = 1'b1;
    lat = -1;
    res = 32'd0;
    @(posedge clk);
    for (int c = 1; c <= 40; c++) begin
      #1;
      if ((slow ? resp0 : resp1) === 1'b1) begin
        lat = c;
        res = slow ? f0 : f1;
        break;
      end
      @(posedge clk);
    end
    if (lat < 0) #1;
    en0 = 1'b0; en1 = 1'b0;
    @(posedge clk); #1;
    after = slow ? resp0 : resp1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en1 = 1'b0; en0 = 1'b0; fn = 3'b000; a = 32'd0; b = 32'd0;
    #2 rst = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    checks++; if (f1 !== 32'd0) begin errors++; $display("FAIL reset_f1: got %h expected 00000000", f1); end
    checks++; if (resp1 !== 1'b0) begin errors++; $display("FAIL reset_resp1: got %b expected 0", resp1); end
    checks++; if (f0 !== 32'd0) begin errors++; $display("FAIL reset_f0: got %h expected 00000000", f0); end
    checks++; if (resp0 !== 1'b0) begin errors++; $display("FAIL reset_resp0: got %b expected 0", resp0); end
    rst = 1'b1;
    exp_f1 = 32'd0;
  endtask

  task automatic test_unsigned();
    int lat; logic [31:0] res; logic after;
    run_op(1'b0, 3'b101, 32'd100, 32'd7, lat, res, after);
    checks++; if (lat !== 33) begin errors++; $display("FAIL divu_lat: got %0d expected 33", lat); end
    checks++; if (res !== 32'd14) begin errors++; $display("FAIL divu_100_7: got %h expected 0000000e", res); end
    checks++; if (after !== 1'b0) begin errors++; $display("FAIL divu_pulse: got resp %b expected 0", after); end
    checks++; if (f1 !== 32'd14) begin errors++; $display("FAIL divu_hold: got %h expected 0000000e", f1); end
    run_op(1'b0, 3'b111, 32'd100, 32'd7, lat, res, after);
    checks++; if (lat !== 33) begin errors++; $display("FAIL remu_lat: got %0d expected 33", lat); end
    checks++; if (res !== 32'd2) begin errors++; $display("FAIL remu_100_7: got %h expected 00000002", res); end
    run_op(1'b0, 3'b101, 32'hFFFF_FFF9, 32'd2, lat, res, after);
    checks++; if (res !== 32'h7FFF_FFFC) begin errors++; $display("FAIL divu_big: got %h expected 7ffffffc", res); end
    run_op(1'b0, 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, lat, res, after);
    checks++; if (lat !== 33) begin errors++; $display("FAIL divu_nospecial_lat: got %0d expected 33", lat); end
    checks++; if (res !== 32'd0) begin errors++; $display("FAIL divu_nospecial: got %h expected 00000000", res); end
    exp_f1 = 32'd0;
  endtask

  task automatic test_signed();
    int lat; logic [31:0] res; logic after;
    run_op(1'b0, 3'b100, 32'hFFFF_FFF9, 32'd2, lat, res, after);
    checks++; if (res !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_m7_2: got %h expected fffffffd", res); end
    run_op(1'b0, 3'b110, 32'hFFFF_FFF9, 32'd2, lat, res, after);
    checks++; if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rem_m7_2: got %h expected ffffffff", res); end
    run_op(1'b0, 3'b100, 32'd7, 32'hFFFF_FFFE, lat, res, after);
    checks++; if (res !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_7_m2: got %h expected fffffffd", res); end
    run_op(1'b0, 3'b110, 32'd7, 32'hFFFF_FFFE, lat, res, after);
    checks++; if (res !== 32'd1) begin errors++; $display("FAIL rem_7_m2: got %h expected 00000001", res); end
    exp_f1 = 32'd1;
  endtask

  task automatic test_div_zero();
    int lat; logic [31:0] res; logic after;
    run_op(1'b0, 3'b101, 32'h1234, 32'd0, lat, res, after);
    checks++; if (lat !== 1) begin errors++; $display("FAIL divu0_fast_lat: got %0d expected 1", lat); end
    checks++; if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu0_fast: got %h expected ffffffff", res); end
    run_op(1'b0, 3'b111, 32'h1234, 32'd0, lat, res, after);
    checks++; if (lat !== 1) begin errors++; $display("FAIL remu0_fast_lat: got %0d expected 1", lat); end
    checks++; if (res !== 32'h1234) begin errors++; $display("FAIL remu0_fast: got %h expected 00001234", res); end
    run_op(1'b0, 3'b110, 32'hFFFF_FFFB, 32'd0, lat, res, after);
    checks++; if (res !== 32'hFFFF_FFFB) begin errors++; $display("FAIL rem0_fast: got %h expected fffffffb", res); end
    run_op(1'b1, 3'b101, 32'h1234, 32'd0, lat, res, after);
    checks++; if (lat !== 33) begin errors++; $display("FAIL divu0_slow_lat: got %0d expected 33", lat); end
    checks++; if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu0_slow: got %h expected ffffffff", res); end
    run_op(1'b1, 3'b111, 32'h1234, 32'd0, lat, res, after);
    checks++; if (lat !== 33) begin errors++; $display("FAIL remu0_slow_lat: got %0d expected 33", lat); end
    checks++; if (res !== 32'h1234) begin errors++; $display("FAIL remu0_slow: got %h expected 00001234", res); end
    run_op(1'b1, 3'b100, 32'hFFFF_FFFB, 32'd0, lat, res, after);
    checks++; if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div0_slow: got %h expected ffffffff", res); end
    run_op(1'b1, 3'b110, 32'hFFFF_FFFB, 32'd0, lat, res, after);
    checks++; if (res !== 32'hFFFF_FFFB) begin errors++; $display("FAIL rem0_slow: got %h expected fffffffb", res); end
    exp_f1 = 32'hFFFF_FFFB;
  endtask

  task automatic test_overflow();
    int lat; logic [31:0] res; logic after;
    run_op(1'b0, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, lat, res, after);
    checks++; if (lat !== 1) begin errors++; $display("FAIL ovf_div_lat: got %0d expected 1", lat); end
    checks++; if (res !== 32'h8000_0000) begin errors++; $display("FAIL ovf_div: got %h expected 80000000", res); end
    checks++; if (after !== 1'b0) begin errors++; $display("FAIL ovf_pulse: got resp %b expected 0", after); end
    run_op(1'b0, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, lat, res, after);
    checks++; if (res !== 32'd0) begin errors++; $display("FAIL ovf_rem: got %h expected 00000000", res); end
    run_op(1'b1, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, lat, res, after);
    checks++; if (lat !== 33) begin errors++; $display("FAIL ovf_div_slow_lat: got %0d expected 33", lat); end
    checks++; if (res !== 32'h8000_0000) begin errors++; $display("FAIL ovf_div_slow: got %h expected 80000000", res); end
    run_op(1'b1, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, lat, res, after);
    checks++; if (res !== 32'd0) begin errors++; $display("FAIL ovf_rem_slow: got %h expected 00000000", res); end
    exp_f1 = 32'd0;
  endtask

  task automatic test_ignore();
    logic seen;
    seen = 1'b0;
    fn = 3'b000; a = 32'd100; b = 32'd7; en1 = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      if (resp1 !== 1'b0) seen = 1'b1;
    end
    en1 = 1'b0;
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL ignore_resp: got resp 1 expected none"); end
    checks++; if (f1 !== exp_f1) begin errors++; $display("FAIL ignore_f: got %h expected %h", f1, exp_f1); end
  endtask

  task automatic test_operand_change();
    int lat; logic [31:0] res;
    lat = -1; res = 32'd0;
    fn = 3'b101; a = 32'd100; b = 32'd7; en1 = 1'b1;
    @(posedge clk); #1;
    a = 32'hDEAD_BEEF; b = 32'd1; fn = 3'b110;
    for (int c = 1; c <= 40; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      if (resp1 === 1'b1) begin lat = c; res = f1; break; end
    end
    en1 = 1'b0;
    @(posedge clk); #1;
    checks++; if (lat !== 33) begin errors++; $display("FAIL opchg_lat: got %0d expected 33", lat); end
    checks++; if (res !== 32'd14) begin errors++; $display("FAIL opchg_f: got %h expected 0000000e", res); end
    exp_f1 = 32'd14;
  endtask

  task automatic test_abort();
    int lat; logic [31:0] res; logic after; logic seen;
    seen = 1'b0;
    fn = 3'b101; a = 32'd1000; b = 32'd3; en1 = 1'b1;
    @(posedge clk);
    repeat (9) @(posedge clk);
    #1 en1 = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (resp1 !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_resp: got resp 1 expected none"); end
    checks++; if (f1 !== exp_f1) begin errors++; $display("FAIL abort_f: got %h expected %h", f1, exp_f1); end
    run_op(1'b0, 3'b101, 32'd9, 32'd3, lat, res, after);
    checks++; if (lat !== 33) begin errors++; $display("FAIL after_abort_lat: got %0d expected 33", lat); end
    checks++; if (res !== 32'd3) begin errors++; $display("FAIL after_abort_f: got %h expected 00000003", res); end
    exp_f1 = 32'd3;
  endtask

  task automatic test_back_to_back();
    int lat1, lat2; logic [31:0] r1, r2; logic mid;
    lat1 = -1; lat2 = -1; r1 = 32'd0; r2 = 32'd0;
    fn = 3'b101; a = 32'd50; b = 32'd5; en1 = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 40; c++) begin
      #1;
      if (resp1 === 1'b1) begin lat1 = c; r1 = f1; break; end
      @(posedge clk);
    end
    if (lat1 < 0) #1;
    fn = 3'b111; b = 32'd7;
    @(posedge clk); #1;
    mid = resp1;
    @(posedge clk);
    for (int c = 1; c <= 40; c++) begin
      #1;
      if (resp1 === 1'b1) begin lat2 = c; r2 = f1; break; end
      @(posedge clk);
    end
    if (lat2 < 0) #1;
    en1 = 1'b0;
    @(posedge clk); #1;
    checks++; if (lat1 !== 33) begin errors++; $display("FAIL b2b_lat1: got %0d expected 33", lat1); end
    checks++; if (r1 !== 32'd10) begin errors++; $display("FAIL b2b_f1: got %h expected 0000000a", r1); end
    checks++; if (mid !== 1'b0) begin errors++; $display("FAIL b2b_pulse: got resp %b expected 0", mid); end
    checks++; if (lat2 !== 33) begin errors++; $display("FAIL b2b_lat2: got %0d expected 33", lat2); end
    checks++; if (r2 !== 32'd1) begin errors++; $display("FAIL b2b_f2: got %h expected 00000001", r2); end
    checks++; if (resp1 !== 1'b0) begin errors++; $display("FAIL b2b_end: got resp %b expected 0", resp1); end
    exp_f1 = 32'd1;
  endtask

  task automatic test_reset_mid();
    logic seen;
    seen = 1'b0;
    fn = 3'b101; a = 32'd1000; b = 32'd7; en1 = 1'b1;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    checks++; if (f1 !== 32'd0) begin errors++; $display("FAIL rstmid_f: got %h expected 00000000", f1); end
    checks++; if (resp1 !== 1'b0) begin errors++; $display("FAIL rstmid_resp: got %b expected 0", resp1); end
    en1 = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      if (resp1 !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rstmid_noresp: got resp 1 expected none"); end
    checks++; if (f1 !== 32'd0) begin errors++; $display("FAIL rstmid_fhold: got %h expected 00000000", f1); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_ignore();
    test_operand_change();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
